// File: rtl/sensor_trace_buffer.sv
// Side-channel trace capture buffer: records one DEPTH-sample trace of TDC
// readings after a cipher start strobe, then drains it byte-by-byte to a UART sender.
module sensor_trace_buffer #(
  parameter int          DEPTH      = 1024,
  parameter int          AW         = 10,
  parameter logic [7:0]  START_MARK = 8'd250,
  parameter logic [7:0]  VALID_MARK = 8'd255
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          arm_i,
  input  logic          abort_i,
  input  logic          trig_i,
  input  logic          ct_vld_i,
  input  logic [7:0]    sample_i,
  output logic [7:0]    tx_data_o,
  output logic          tx_valid_o,
  input  logic          tx_ready_i,
  output logic          tx_last_o,
  output logic          busy_o,
  output logic          full_o,
  output logic          ct_seen_o,
  output logic [AW-1:0] ct_pos_o,
  output logic          missed_o
);

  typedef enum logic [2:0] {IDLE, ARMED, CAPTURE, FETCH, PRESENT} state_t;

  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

  state_t        state;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [7:0]    mem [DEPTH];
  logic [7:0]    rd_q;
  logic          we;
  logic [AW-1:0] waddr;
  logic [7:0]    wdata;

  // ARMED keeps stamping the start marker at address 0 so a trace that never
  // triggers is recognisable; CAPTURE overwrites it on its first cycle.
  always_comb begin
    we    = 1'b0;
    waddr = '0;
    wdata = START_MARK;
    if (state == ARMED) begin
      we = 1'b1;
    end else if (state == CAPTURE) begin
      we    = 1'b1;
      waddr = wr_ptr;
      wdata = ct_vld_i ? VALID_MARK : sample_i;
    end
  end

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Read register only loads in FETCH, so tx_data_o holds through PRESENT.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                rd_q <= '0;
    else if (state == FETCH) rd_q <= mem[rd_ptr];
  end

  assign tx_data_o = rd_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      tx_valid_o <= 1'b0;
      tx_last_o  <= 1'b0;
      busy_o     <= 1'b0;
      full_o     <= 1'b0;
      ct_seen_o  <= 1'b0;
      ct_pos_o   <= '0;
      missed_o   <= 1'b0;
    end else if (abort_i) begin
      state      <= IDLE;
      tx_valid_o <= 1'b0;
      tx_last_o  <= 1'b0;
      busy_o     <= 1'b0;
      full_o     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (arm_i) begin
            state     <= ARMED;
            busy_o    <= 1'b1;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            ct_seen_o <= 1'b0;
            ct_pos_o  <= '0;
            missed_o  <= 1'b0;
          end
        end
        ARMED: begin
          if (trig_i) begin
            state  <= CAPTURE;
            wr_ptr <= '0;
          end
        end
        CAPTURE: begin
          if (trig_i) missed_o <= 1'b1;
          if (ct_vld_i && !ct_seen_o) begin
            ct_seen_o <= 1'b1;
            ct_pos_o  <= wr_ptr;
          end
          if (wr_ptr == LAST) begin
            state  <= FETCH;
            full_o <= 1'b1;
            rd_ptr <= '0;
          end else begin
            wr_ptr <= wr_ptr + 1'b1;
          end
        end
        FETCH: begin
          if (trig_i) missed_o <= 1'b1;
          state      <= PRESENT;
          tx_valid_o <= 1'b1;
          tx_last_o  <= (rd_ptr == LAST);
        end
        PRESENT: begin
          if (trig_i) missed_o <= 1'b1;
          if (tx_valid_o && tx_ready_i) begin
            tx_valid_o <= 1'b0;
            tx_last_o  <= 1'b0;
            if (rd_ptr == LAST) begin
              state  <= IDLE;
              full_o <= 1'b0;
              busy_o <= 1'b0;
            end else begin
              rd_ptr <= rd_ptr + 1'b1;
              state  <= FETCH;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sensor_trace_buffer.sv
// Randomized scoreboard bench for sensor_trace_buffer: capture stimulus pushes
// expected bytes, an independent monitor pops them on every tx handshake.
module tb_sensor_trace_buffer;

  localparam int DEPTH = 1024;
  localparam int AW    = 10;

  logic          clk = 1'b0;
  logic          rst;
  logic          arm_i, abort_i, trig_i, ct_vld_i, tx_ready_i;
  logic [7:0]    sample_i;
  logic [7:0]    tx_data_o;
  logic          tx_valid_o, tx_last_o, busy_o, full_o, ct_seen_o, missed_o;
  logic [AW-1:0] ct_pos_o;

  sensor_trace_buffer #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk(clk), .rst(rst), .arm_i(arm_i), .abort_i(abort_i), .trig_i(trig_i),
    .ct_vld_i(ct_vld_i), .sample_i(sample_i), .tx_data_o(tx_data_o),
    .tx_valid_o(tx_valid_o), .tx_ready_i(tx_ready_i), .tx_last_o(tx_last_o),
    .busy_o(busy_o), .full_o(full_o), .ct_seen_o(ct_seen_o), .ct_pos_o(ct_pos_o),
    .missed_o(missed_o)
  );

  always #5 clk = ~clk;

  typedef struct { logic [7:0] data; logic last; } exp_t;
  exp_t exp_q[$];

  int n_cmp = 0;
  int n_err = 0;
  int ready_mode = 0;   // 0: always ready, 1: random, 2: never
  int vld_a = -1, vld_b = -1;
  logic exp_seen, exp_missed;
  int   exp_pos;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      tx_ready_i = (ready_mode == 0) ? 1'b1 :
                   (ready_mode == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
    end
  end

  // Monitor: samples 1 ns after the falling edge, when the next edge's inputs are settled.
  logic       pv = 1'b0, phs = 1'b0;
  logic [7:0] pd = '0;
  int         cyc = 0, last_hs = -10, n_bytes = 0;
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #1;
      cyc++;
      if (!rst && pv && !phs && tx_valid_o) chk("hold_stable", tx_data_o, pd);
      if (!rst && tx_valid_o && tx_ready_i) begin
        if (exp_q.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL unexpected_byte: got %0d expected no byte", tx_data_o);
        end else begin
          e = exp_q.pop_front();
          chk($sformatf("byte%0d", n_bytes), tx_data_o, e.data);
          chk($sformatf("last%0d", n_bytes), tx_last_o, e.last);
          chk("hs_spacing", (cyc - last_hs) >= 2, 1);
          n_bytes++;
        end
        last_hs = cyc;
      end
      pv  = tx_valid_o;
      phs = tx_valid_o && tx_ready_i;
      pd  = tx_data_o;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic capture(input int mode, input int abort_at, input int trig_at);
    exp_t e;
    logic [7:0] s;
    logic v;
    exp_seen = 1'b0; exp_pos = 0; exp_missed = 1'b0;
    @(negedge clk) arm_i = 1'b1;
    @(negedge clk) arm_i = 1'b0; trig_i = 1'b1; sample_i = 8'hA5;
    @(negedge clk) trig_i = 1'b0;
    for (int k = 0; k < DEPTH; k++) begin
      if (k == abort_at) begin
        abort_i = 1'b1; ct_vld_i = 1'b0;
        @(negedge clk) abort_i = 1'b0;
        exp_q.delete();
        return;
      end
      s = (mode == 0) ? k[7:0] : 8'($urandom);
      v = (k == vld_a) || (k == vld_b);
      trig_i = (k == trig_at);
      if (k == trig_at) exp_missed = 1'b1;
      sample_i = s; ct_vld_i = v;
      e.data = v ? 8'd255 : s;
      e.last = (k == DEPTH - 1);
      exp_q.push_back(e);
      if (v && !exp_seen) begin exp_seen = 1'b1; exp_pos = k; end
      @(negedge clk);
    end
    trig_i = 1'b0; ct_vld_i = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int c = 0;
    while ((exp_q.size() != 0 || busy_o) && c < 20000) begin
      @(negedge clk);
      c++;
    end
    @(negedge clk);
    chk({name, "_drain_done"}, c < 20000, 1);
    chk({name, "_full_after"}, full_o, 0);
    chk({name, "_busy_after"}, busy_o, 0);
    chk({name, "_ct_seen"}, ct_seen_o, exp_seen);
    chk({name, "_ct_pos"}, ct_pos_o, exp_pos);
    chk({name, "_missed"}, missed_o, exp_missed);
  endtask

  initial begin
    int c;
    logic saw;
    rst = 1'b1; arm_i = 0; abort_i = 0; trig_i = 0; ct_vld_i = 0; sample_i = 0;
    tx_ready_i = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_tx_valid", tx_valid_o, 0);
    chk("rst_tx_last", tx_last_o, 0);
    chk("rst_full", full_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_ct_seen", ct_seen_o, 0);
    chk("rst_ct_pos", ct_pos_o, 0);
    chk("rst_missed", missed_o, 0);
    chk("rst_tx_data", tx_data_o, 0);
    rst = 1'b0;
    @(negedge clk);
    // trig while idle must be ignored
    trig_i = 1'b1; @(negedge clk) trig_i = 1'b0; @(negedge clk);
    chk("idle_trig_busy", busy_o, 0);

    // A: counting samples, always ready
    ready_mode = 0;
    capture(0, -1, -1);
    wait_drain("A");

    // B: ciphertext marks at 37 and 80, random ready
    ready_mode = 1; vld_a = 37; vld_b = 80;
    capture(1, -1, -1);
    wait_drain("B");
    vld_a = -1; vld_b = -1;

    // C: extra triggers during capture and during drain
    capture(1, -1, 300);
    c = 0;
    while (!tx_valid_o && c < 100) begin @(negedge clk); c++; end
    chk("C_present_reached", tx_valid_o, 1);
    trig_i = 1'b1; exp_missed = 1'b1;
    @(negedge clk) trig_i = 1'b0;
    wait_drain("C");
    @(negedge clk) arm_i = 1'b1;
    @(negedge clk) arm_i = 1'b0;
    chk("C_arm_clears_missed", missed_o, 0);
    chk("C_armed_busy", busy_o, 1);
    abort_i = 1'b1; @(negedge clk) abort_i = 1'b0;

    // D: abort mid-capture, then a clean trace
    ready_mode = 0;
    vld_a = 20;
    capture(1, 500, -1);
    chk("D_abort_busy", busy_o, 0);
    chk("D_abort_full", full_o, 0);
    chk("D_abort_valid", tx_valid_o, 0);
    vld_a = -1;
    capture(1, -1, -1);
    wait_drain("D");

    // E: async reset while presenting, then arm without trigger
    ready_mode = 2;
    capture(1, -1, -1);
    c = 0;
    while (!tx_valid_o && c < 100) begin @(negedge clk); c++; end
    chk("E_present_reached", tx_valid_o, 1);
    #3 rst = 1'b1;
    #1;
    chk("E_async_valid", tx_valid_o, 0);
    chk("E_async_busy", busy_o, 0);
    chk("E_async_full", full_o, 0);
    exp_q.delete();
    @(negedge clk) rst = 1'b0;
    ready_mode = 0;
    @(negedge clk) arm_i = 1'b1;
    @(negedge clk) arm_i = 1'b0;
    saw = 1'b0;
    repeat (50) begin @(negedge clk); if (tx_valid_o) saw = 1'b1; end
    chk("E_armed_no_valid", saw, 0);
    chk("E_armed_busy", busy_o, 1);
    abort_i = 1'b1; @(negedge clk) abort_i = 1'b0;
    @(negedge clk);
    chk("E_bytes_total", n_bytes, 4 * DEPTH);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/sensor_trace_buffer.md
SENSOR_TRACE_BUFFER -- requirements
Module: sensor_trace_buffer

Interface
REQ-001 Parameter DEPTH, 1024, samples per trace; power of two, 16 minimum.
REQ-002 Parameter AW, 10, address width; equals log2(DEPTH).
REQ-003 Parameter START_MARK, 8'd250, byte written to address 0 while armed.
REQ-004 Parameter VALID_MARK, 8'd255, byte written instead of the sample in any cycle with ct_vld_i=1.
REQ-005 Port clk  input  1  sole clock; the sensor sampling clock, rising edge.
REQ-006 Port rst  input  1  reset, asynchronous, active-high.
REQ-007 Port arm_i  input  1  one-cycle pulse; arms capture for the next trace.
REQ-008 Port abort_i  input  1  level; forces return to IDLE.
REQ-009 Port trig_i  input  1  cipher start strobe (Drdy); starts capture.
REQ-010 Port ct_vld_i  input  1  ciphertext valid strobe (Dvld).
REQ-011 Port sample_i  input  8  decoded TDC value (ones count), one per cycle.
REQ-012 Port tx_data_o  output  8  trace byte offered to the UART sender.
REQ-013 Port tx_valid_o  output  1  tx_data_o is valid.
REQ-014 Port tx_ready_i  input  1  sender accepts the byte when tx_valid_o=1.
REQ-015 Port tx_last_o  output  1  high with the byte at address DEPTH-1.
REQ-016 Port busy_o  output  1  high in every state except IDLE.
REQ-017 Port full_o  output  1  high from the end of capture until drain completes.
REQ-018 Port ct_seen_o  output  1  at least one VALID_MARK was written in this trace.
REQ-019 Port ct_pos_o  output  AW  address of the first VALID_MARK in this trace.
REQ-020 Port missed_o  output  1  sticky; trig_i was seen while busy and not ARMED.

Function
REQ-021 The FSM SHALL have states IDLE, ARMED, CAPTURE, FETCH, PRESENT; storage is a DEPTH x 8 synchronous-read RAM.
REQ-022 IDLE: arm_i=1 -> ARMED; wr_ptr, rd_ptr, ct_seen_o, ct_pos_o and missed_o are cleared; trig_i is ignored.
REQ-023 ARMED: each cycle writes START_MARK to address 0; trig_i=1 -> CAPTURE with wr_ptr=0.
REQ-024 CAPTURE: each cycle writes (ct_vld_i ? VALID_MARK : sample_i) to address wr_ptr, then increments wr_ptr.
REQ-025 The first cycle in CAPTURE SHALL write address 0, overwriting START_MARK.
REQ-026 On the first VALID_MARK write, ct_seen_o SHALL go 1 and ct_pos_o SHALL latch wr_ptr; later marks do not update ct_pos_o.
REQ-027 The write at wr_ptr=DEPTH-1 SHALL be the last write; the FSM then moves to FETCH with full_o=1 and rd_ptr=0; wr_ptr does not wrap.
REQ-028 FETCH: the RAM is read at rd_ptr and tx_valid_o=0; next state is PRESENT.
REQ-029 PRESENT: tx_valid_o=1 and tx_data_o holds the read data; it is stable until tx_valid_o && tx_ready_i.
REQ-030 On a PRESENT handshake with rd_ptr<DEPTH-1: rd_ptr increments -> FETCH (one bubble cycle per byte).
REQ-031 On a PRESENT handshake with rd_ptr=DEPTH-1 (tx_last_o=1): the FSM SHALL go to IDLE and clear full_o.
REQ-032 trig_i=1 in CAPTURE, FETCH or PRESENT SHALL set missed_o and SHALL NOT disturb capture or drain.
REQ-033 abort_i=1 SHALL go to IDLE on the next edge from any state and deassert tx_valid_o, full_o and busy_o; RAM contents are undefined after an abort.
REQ-034 abort_i SHALL take priority over arm_i, trig_i and any handshake in the same cycle.
REQ-035 arm_i outside IDLE SHALL be ignored.
REQ-036 Capture latency: the sample present on the cycle trig_i is sampled in ARMED SHALL NOT be stored; address 0 holds sample_i from the first CAPTURE cycle.

Reset
REQ-037 While rst=1: state=IDLE.
REQ-038 While rst=1: tx_valid_o=0, tx_last_o=0, full_o=0, busy_o=0.
REQ-039 While rst=1: ct_seen_o=0, ct_pos_o=0, missed_o=0, wr_ptr=0, rd_ptr=0; tx_data_o=0.
REQ-040 RAM contents SHALL NOT be reset.
REQ-041 Reset asserted mid-capture or mid-drain SHALL return to IDLE immediately.

Verification
REQ-042 arm, trig, sample_i=address[7:0] counting, tx_ready_i=1 -> 1024 bytes out as 0..255 repeating; tx_last_o only on byte 1024; full_o then 0.
REQ-043 ct_vld_i pulsed at capture cycles 37 and 80 -> bytes 37 and 80 are 255; ct_seen_o=1; ct_pos_o=37.
REQ-044 tx_ready_i toggling pseudo-randomly -> each byte is held stable until its handshake; no byte lost or duplicated; at most one byte accepted per two cycles.
REQ-045 trig_i pulsed during CAPTURE and again during PRESENT -> missed_o=1; the trace is identical to a run without the extra pulses; the next arm_i clears missed_o.
REQ-046 abort_i at capture cycle 500, then arm and trig -> clean new trace, ct_seen_o=0 until a new ct_vld_i.
REQ-047 rst asserted asynchronously during PRESENT -> tx_valid_o and busy_o fall before the next clk edge; arm_i without trig_i -> no tx_valid_o.
